hazard_tnew_pipe: RTL
=====================

Name: hazard_tnew_pipe

Overview:
- Pipeline of hazard bookkeeping registers: destination register, write enable and Tnew for each in-flight instruction in the E, M and W stages.
- Produces the DE/EM/MW A3, RegWE and Tnew signals that the stall controller compares against the decode-stage operands.
- Sits between decode, which supplies per-instruction A3/RegWE/Tnew, and the stall controller, whose stall output it consumes to insert bubbles.
- Also keeps a saturating stall-cycle counter for debug and performance.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk input 1: system clock; all state updates on the rising edge.
- reset input 1: synchronous, active-high reset.
- stall input 1: from the stall controller; 1 means the decode instruction is held and a bubble enters E.
- IDA3 input 5: destination register of the decode-stage instruction.
- IDRegWE input 1: decode-stage instruction writes the register file.
- IDTnew input 2: cycles until the result is available, counted from E-stage entry (ALU=1, load=2, link/lui-type=0).
- DEA3 output 5: E-stage destination register.
- DERegWE output 1: E-stage write enable.
- DETnew output 2: E-stage Tnew.
- EMA3 output 5: M-stage destination register.
- EMRegWE output 1: M-stage write enable.
- EMTnew output 2: M-stage Tnew.
- MWA3 output 5: W-stage destination register.
- MWRegWE output 1: W-stage write enable.
- MWTnew output 2: W-stage Tnew.
- stall_cnt output CNT_W: number of cycles with stall=1 since reset, saturating.

Behaviour:
- Reset (synchronous, reset=1 at the edge):
  - All A3, RegWE and Tnew outputs become 0.
  - stall_cnt becomes 0.
  - reset has priority over every other input.
- Normalisation at capture: if IDA3==0, the captured RegWE is 0; A3 and Tnew are still captured as given.
- Each rising edge with reset=0, all three stages update in parallel from their pre-edge values:
  - DE stage:
    - stall=0: DE <= {IDA3, normalised IDRegWE, IDTnew}.
    - stall=1: DE <= bubble {0, 0, 0}.
  - EM stage: EM <= {DEA3, DERegWE, dec(DETnew)}.
  - MW stage: MW <= {EMA3, EMRegWE, dec(EMTnew)}.
  - dec(x) = x-1 if x>0, else 0. Tnew never wraps: 0 stays 0.
- stall affects only the DE capture. EM and MW always advance, so a bubble drains normally.
- Latency:
  - An instruction captured at edge N appears on DE after edge N.
  - It appears on EM after edge N+1 with Tnew-1.
  - It appears on MW after edge N+2 with Tnew-2, floored at 0.
  - It leaves the pipe after edge N+3.
- Outputs are registered only; there is no combinational path from ID* or stall to any output.
- stall_cnt:
  - Increments by 1 on each edge with stall=1 and reset=0.
  - Holds at all-ones (2^CNT_W-1) once reached.
- Simultaneous events:
  - reset and stall both 1: reset wins and the counter is cleared, not incremented.
  - stall held for k consecutive cycles inserts k bubbles into DE; the decode inputs are ignored for those cycles.
- Reset mid-operation clears in-flight entries immediately. No partial drain occurs.
- Tnew input value 3 is legal and decrements 3→2→1 across DE, EM and MW.

Test Plan:
- Reset, then IDA3=5, IDRegWE=1, IDTnew=2, stall=0 for one cycle, then zeros.
  - Required: DE={5,1,2}, then EM={5,1,1}, then MW={5,1,0}, then all stages 0.
- IDA3=0, IDRegWE=1, IDTnew=1.
  - Required: DERegWE=0 and DEA3=0.
- Load in DE ({8,1,2}) with stall=1 for one cycle, while ID presents {9,1,1}.
  - Required: next DE={0,0,0}, EM={8,1,1}, stall_cnt=1.
  - Next cycle with stall=0: DE={9,1,1}.
- Tnew=0 instruction ({31,1,0}).
  - Required: EMTnew=0 and MWTnew=0, with no wrap to 3.
- CNT_W=4, stall=1 held for 20 cycles.
  - Required: stall_cnt reaches 15 and stays at 15.
- Pipeline full with DE/EM/MW all valid, then reset=1 together with stall=1 for one edge.
  - Required: all outputs 0 and stall_cnt=0 on the following cycle.

Source files
------------

// File: rtl/hazard_tnew_pipe.sv
// hazard_tnew_pipe: E/M/W-stage hazard bookkeeping (A3, RegWE, Tnew) feeding
// the stall controller, plus a saturating stall-cycle counter.
module hazard_tnew_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [4:0]       IDA3,
  input  logic             IDRegWE,
  input  logic [1:0]       IDTnew,
  output logic [4:0]       DEA3,
  output logic             DERegWE,
  output logic [1:0]       DETnew,
  output logic [4:0]       EMA3,
  output logic             EMRegWE,
  output logic [1:0]       EMTnew,
  output logic [4:0]       MWA3,
  output logic             MWRegWE,
  output logic [1:0]       MWTnew,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       id_we_norm;
  logic [1:0] de_tnew_dec;
  logic [1:0] em_tnew_dec;

  // Register $0 is never a real destination; Tnew decrements floor at zero.
  always_comb begin
    id_we_norm  = IDRegWE && (IDA3 != 5'd0);
    de_tnew_dec = (DETnew != 2'd0) ? DETnew - 2'd1 : 2'd0;
    em_tnew_dec = (EMTnew != 2'd0) ? EMTnew - 2'd1 : 2'd0;
  end

  // DE stage: capture decode instruction, or a bubble while stalled.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      DEA3    <= '0;
      DERegWE <= 1'b0;
      DETnew  <= '0;
    end else begin
      DEA3    <= IDA3;
      DERegWE <= id_we_norm;
      DETnew  <= IDTnew;
    end
  end

  // EM and MW stages always advance so bubbles drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      EMA3    <= '0;
      EMRegWE <= 1'b0;
      EMTnew  <= '0;
      MWA3    <= '0;
      MWRegWE <= 1'b0;
      MWTnew  <= '0;
    end else begin
      EMA3    <= DEA3;
      EMRegWE <= DERegWE;
      EMTnew  <= de_tnew_dec;
      MWA3    <= EMA3;
      MWRegWE <= EMRegWE;
      MWTnew  <= em_tnew_dec;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
